// File: rtl/reg_wb_arbiter_pkg.sv
// Shared write-back definitions: field widths, entry layout and source indices.
package reg_wb_arbiter_pkg;

    localparam int unsigned REG_DATA_WIDTH  = 32;
    localparam int unsigned REG_ADDR_WIDTH  = 5;
    localparam int unsigned COMMIT_ID_WIDTH = 4;

    localparam int unsigned WB_SRC_ALU = 0;
    localparam int unsigned WB_SRC_MUL = 1;
    localparam int unsigned WB_SRC_DIV = 2;
    localparam int unsigned WB_SRC_LSU = 3;

    // Same field order as the write-back FIFO entry
    typedef struct packed {
        logic [REG_DATA_WIDTH-1:0]  wdata;
        logic [REG_ADDR_WIDTH-1:0]  waddr;
        logic [COMMIT_ID_WIDTH-1:0] commit_id;
    } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arbiter.sv
// Rotating-priority one-hot arbiter; search starts at ptr and wraps. Purely combinational.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    // First requester at or after ptr, modulo NUM_REQ (explicit wrap, any NUM_REQ)
    always_comb begin
        int unsigned idx;
        logic [PTR_W-1:0] sel;
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = PTR_W'(idx);
            if (!grant_valid && req[sel]) begin
                grant[sel]  = 1'b1;
                grant_idx   = sel;
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin scheduler sharing the regfile write port among write-back FIFOs.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_SRC = 4,
    localparam int unsigned PTR_W   = $clog2(NUM_SRC)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NUM_SRC-1:0]                   src_valid_i,
    input  logic [NUM_SRC*REG_DATA_WIDTH-1:0]    src_wdata_i,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0]    src_waddr_i,
    input  logic [NUM_SRC*COMMIT_ID_WIDTH-1:0]   src_commit_id_i,
    input  logic                                 hold_i,
    output logic [NUM_SRC-1:0]                   src_pop_o,
    output logic                                 reg_we_o,
    output logic [REG_ADDR_WIDTH-1:0]            reg_waddr_o,
    output logic [REG_DATA_WIDTH-1:0]            reg_wdata_o,
    output logic                                 commit_valid_o,
    output logic [COMMIT_ID_WIDTH-1:0]           commit_id_o,
    output logic [PTR_W-1:0]                     grant_src_o
);

    logic [PTR_W-1:0]   rr_ptr;
    logic [NUM_SRC-1:0] req_masked;
    logic [NUM_SRC-1:0] grant_vec;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic [PTR_W-1:0]   ptr_next;
    wb_req_t            heads [NUM_SRC];
    wb_req_t            sel_req;

    // Unpack the flat FIFO head buses into per-source entries
    always_comb begin
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            heads[k].wdata     = src_wdata_i[k*REG_DATA_WIDTH +: REG_DATA_WIDTH];
            heads[k].waddr     = src_waddr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            heads[k].commit_id = src_commit_id_i[k*COMMIT_ID_WIDTH +: COMMIT_ID_WIDTH];
        end
    end

    assign req_masked = hold_i ? '0 : src_valid_i;

    rr_arbiter #(
        .NUM_REQ (NUM_SRC)
    ) u_rr_arbiter (
        .req         (req_masked),
        .ptr         (rr_ptr),
        .grant       (grant_vec),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Pop is the one-hot grant, forced off while reset is held
    assign src_pop_o = rst_n ? grant_vec : '0;
    assign sel_req   = heads[grant_idx];
    assign ptr_next  = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);

    // Capture the granted head; strobes drop when idle, payload holds
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr         <= '0;
            reg_we_o       <= 1'b0;
            reg_waddr_o    <= '0;
            reg_wdata_o    <= '0;
            commit_valid_o <= 1'b0;
            commit_id_o    <= '0;
            grant_src_o    <= '0;
        end else if (grant_valid) begin
            rr_ptr         <= ptr_next;
            reg_we_o       <= (sel_req.waddr != '0);
            reg_waddr_o    <= sel_req.waddr;
            reg_wdata_o    <= sel_req.wdata;
            commit_valid_o <= 1'b1;
            commit_id_o    <= sel_req.commit_id;
            grant_src_o    <= grant_idx;
        end else begin
            reg_we_o       <= 1'b0;
            commit_valid_o <= 1'b0;
        end
    end

endmodule
